// File: rtl/ram_dp_be_clr.sv
// True dual-port RAM with byte write enables, 1/2-cycle read latency,
// selectable read-during-write behaviour and a hardware clear sweep.
module ram_dp_be_clr #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear_start,
  output logic                                busy,
  input  logic                                a_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    a_we,
  input  logic [ADDR_WIDTH-1:0]               a_addr,
  input  logic [DATA_WIDTH-1:0]               a_din,
  output logic [DATA_WIDTH-1:0]               a_dout,
  output logic                                a_valid,
  input  logic                                b_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    b_we,
  input  logic [ADDR_WIDTH-1:0]               b_addr,
  input  logic [DATA_WIDTH-1:0]               b_din,
  output logic [DATA_WIDTH-1:0]               b_dout,
  output logic                                b_valid
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    clr_we;
  logic                    acc_ok;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [1:0]                  en;
  logic [1:0][BE_WIDTH-1:0]    we;
  logic [1:0][ADDR_WIDTH-1:0]  addr;
  logic [1:0][DATA_WIDTH-1:0]  din;
  logic [1:0]                  acc;
  logic [1:0][BE_WIDTH-1:0]    wr;
  logic [1:0][DATA_WIDTH-1:0]  rdata;

  logic [1:0][DATA_WIDTH-1:0]  s1_data_q, s1_data_d;
  logic [1:0]                  s1_valid_q, s1_valid_d;
  logic [1:0][DATA_WIDTH-1:0]  out_data;
  logic [1:0]                  out_valid;

  assign en   = {b_en, a_en};
  assign we   = {b_we, a_we};
  assign addr = {b_addr, a_addr};
  assign din  = {b_din, a_din};

  // Clear FSM: the request cycle itself never accepts port accesses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    acc_ok  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          acc_ok = 1'b1;
        end
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      busy_q  <= (CLEAR_ON_RESET != 0);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port read data; other-port writes are never forwarded.
  always_comb begin
    acc   = '0;
    wr    = '0;
    rdata = '0;
    for (int p = 0; p < 2; p++) begin
      acc[p]   = acc_ok & en[p];
      wr[p]    = acc[p] ? we[p] : '0;
      rdata[p] = mem[addr[p]];
      if (WRITE_MODE == 0) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (wr[p][i]) rdata[p][i*BYTE_WIDTH +: BYTE_WIDTH] = din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Port B first so port A overrides on bytes both ports enable.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int p = 1; p >= 0; p--) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (wr[p][i]) mem[addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = acc;
    s1_data_d  = s1_data_q;
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) s1_data_d[p] = rdata[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q  <= '0;
      s1_valid_q <= '0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  if (READ_LATENCY >= 2) begin : g_lat2
    logic [1:0][DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic [1:0]                 s2_valid_q, s2_valid_d;

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s2_data_q;
      for (int p = 0; p < 2; p++) begin
        if (s1_valid_q[p]) s2_data_d[p] = s1_data_q[p];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_data_q  <= '0;
        s2_valid_q <= '0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s2_valid_d;
      end
    end

    assign out_data  = s2_data_q;
    assign out_valid = s2_valid_q;
  end else begin : g_lat1
    assign out_data  = s1_data_q;
    assign out_valid = s1_valid_q;
  end

  assign busy    = busy_q;
  assign a_dout  = out_data[0];
  assign a_valid = out_valid[0];
  assign b_dout  = out_data[1];
  assign b_valid = out_valid[1];

endmodule

// File: tb/tb_ram_dp_be_clr.sv
// Scoreboard bench: two instances (latency 1 / write-first, latency 2 / read-first)
// share one stimulus stream; a negedge monitor checks every result strobe.
module tb_ram_dp_be_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_start = 1'b0;
  logic        a_en = 1'b0, b_en = 1'b0;
  logic [3:0]  a_we = '0, b_we = '0;
  logic [3:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_din = '0, b_din = '0;

  logic        busy0, busy1;
  logic [31:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic        a_valid0, b_valid0, a_valid1, b_valid1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t qa0[$], qb0[$], qa1[$], qb1[$];
  logic [31:0] last_d [4] = '{default: 32'h0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_dp_be_clr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .READ_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst(rst), .clear_start(clear_start), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout0), .a_valid(a_valid0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout0), .b_valid(b_valid0)
  );

  ram_dp_be_clr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .READ_LATENCY(2), .WRITE_MODE(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst(rst), .clear_start(clear_start), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout1), .a_valid(a_valid1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout1), .b_valid(b_valid1)
  );

  function automatic string pname(input int idx);
    case (idx)
      0: return "lat1_wm0_portA";
      1: return "lat1_wm0_portB";
      2: return "lat2_wm1_portA";
      default: return "lat2_wm1_portB";
    endcase
  endfunction

  function automatic int qsize(input int idx);
    case (idx)
      0: return qa0.size();
      1: return qb0.size();
      2: return qa1.size();
      default: return qb1.size();
    endcase
  endfunction

  function automatic exp_t qpeek(input int idx);
    case (idx)
      0: return qa0[0];
      1: return qb0[0];
      2: return qa1[0];
      default: return qb1[0];
    endcase
  endfunction

  task automatic qdrop(input int idx);
    case (idx)
      0: void'(qa0.pop_front());
      1: void'(qb0.pop_front());
      2: void'(qa1.pop_front());
      default: void'(qb1.pop_front());
    endcase
  endtask

  // Monitor: result strobes must match the queue head in data and cycle.
  task automatic mon(input int idx, input logic v, input logic [31:0] d);
    exp_t e;
    checks++;
    if (rst) begin
      if (v !== 1'b0 || d !== 32'h0) begin
        failures++;
        $display("FAIL %s in_reset: valid=%b dout=%h, want valid=0 dout=0", pname(idx), v, d);
      end
      last_d[idx] = 32'h0;
    end else if (v === 1'b1) begin
      if (qsize(idx) == 0) begin
        failures++;
        $display("FAIL %s spurious_valid: cycle=%0d dout=%h, no result expected", pname(idx), cyc, d);
      end else begin
        e = qpeek(idx);
        qdrop(idx);
        if (d !== e.data || cyc != e.due) begin
          failures++;
          $display("FAIL %s result: dout=%h cycle=%0d, want dout=%h cycle=%0d",
                   pname(idx), d, cyc, e.data, e.due);
        end
      end
      last_d[idx] = d;
    end else begin
      if (d !== last_d[idx]) begin
        failures++;
        $display("FAIL %s dout_hold: dout=%h, want %h", pname(idx), d, last_d[idx]);
      end
      if (qsize(idx) > 0) begin
        e = qpeek(idx);
        if (cyc >= e.due) begin
          failures++;
          $display("FAIL %s missing_valid: cycle=%0d, want dout=%h at cycle=%0d", pname(idx), cyc, e.data, e.due);
          qdrop(idx);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_valid0, a_dout0);
    mon(1, b_valid0, b_dout0);
    mon(2, a_valid1, a_dout1);
    mon(3, b_valid1, b_dout1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", nm, act, act, exp, exp);
    end
  endtask

  // Close the current cycle: idle all request inputs after the next edge.
  task automatic next();
    @(posedge clk);
    #1;
    a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0; clear_start = 1'b0;
  endtask

  // e0: expected result from write-first dut0; e1: from read-first dut1.
  task automatic pa(input logic [3:0] we, input logic [3:0] ad, input logic [31:0] dn,
                    input logic [31:0] e0, input logic [31:0] e1);
    a_en = 1'b1; a_we = we; a_addr = ad; a_din = dn;
    qa0.push_back('{e0, cyc + 1});
    qa1.push_back('{e1, cyc + 2});
  endtask

  task automatic pb(input logic [3:0] we, input logic [3:0] ad, input logic [31:0] dn,
                    input logic [31:0] e0, input logic [31:0] e1);
    b_en = 1'b1; b_we = we; b_addr = ad; b_din = dn;
    qb0.push_back('{e0, cyc + 1});
    qb1.push_back('{e1, cyc + 2});
  endtask

  // Count busy cycles of both instances; optionally poke ports and re-request clear.
  task automatic sweep(input string nm, input bit poke);
    int n0 = 0;
    int n1 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy0 && !busy1) break;
      if (busy0) n0++;
      if (busy1) n1++;
      @(posedge clk);
      #1;
      if (poke) begin
        a_en = 1'b1; a_addr = 4'(k); clear_start = (k == 5);
      end
    end
    a_en = 1'b0; clear_start = 1'b0;
    chk({nm, "_busy_lat1"}, 32'(n0), 32'd16);
    chk({nm, "_busy_lat2"}, 32'(n1), 32'd16);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) begin
      next();
      pa(4'h0, 4'(i), 32'hFFFF_FFFF, 32'h0, 32'h0);
      pb(4'h0, 4'(15 - i), 32'hFFFF_FFFF, 32'h0, 32'h0);
    end
  endtask

  function automatic logic [31:0] known_old(input int i);
    case (i)
      3: return 32'hDEAD_55EF;
      5: return 32'h2222_2222;
      7: return 32'h1234_5678;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy_lat1", 32'(busy0), 32'd1);
    chk("reset_busy_lat2", 32'(busy1), 32'd1);

    next();
    rst = 1'b0;
    sweep("post_reset", 1'b0);
    read_all_zero();

    // Byte-enable merge; port B read sees merged word.
    next(); pa(4'hF, 4'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0);
    next(); pa(4'h2, 4'd3, 32'h0000_5500, 32'hDEAD_55EF, 32'hDEAD_BEEF);
    next(); pb(4'h0, 4'd3, 32'h0, 32'hDEAD_55EF, 32'hDEAD_55EF);

    // Same-port read-during-write.
    next(); pa(4'hF, 4'd5, 32'h1111_1111, 32'h1111_1111, 32'h0);
    next(); pa(4'hF, 4'd5, 32'h2222_2222, 32'h2222_2222, 32'h1111_1111);

    // Cross-port collision on addr 7, then readback and read-vs-write.
    next();
    pa(4'h3, 4'd7, 32'hAAAA_AAAA, 32'h0000_AAAA, 32'h0);
    pb(4'h6, 4'd7, 32'hBBBB_BBBB, 32'h00BB_BB00, 32'h0);
    next();
    pa(4'h0, 4'd7, 32'h0, 32'h00BB_AAAA, 32'h00BB_AAAA);
    pb(4'h0, 4'd7, 32'h0, 32'h00BB_AAAA, 32'h00BB_AAAA);
    next();
    pa(4'hF, 4'd7, 32'h1234_5678, 32'h1234_5678, 32'h00BB_AAAA);
    pb(4'h0, 4'd7, 32'h0, 32'h00BB_AAAA, 32'h00BB_AAAA);
    next(); pb(4'h0, 4'd7, 32'h0, 32'h1234_5678, 32'h1234_5678);

    // Fill, then clear on demand with ignored accesses and a repeated request.
    for (int i = 0; i < 16; i++) begin
      next();
      pa(4'hF, 4'(i), 32'hC0DE_0000 | 32'(i), 32'hC0DE_0000 | 32'(i), known_old(i));
    end
    next();
    clear_start = 1'b1; a_en = 1'b1; a_addr = 4'd1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    sweep("clear_req", 1'b1);
    read_all_zero();

    // Reset in the middle of a sweep restarts it from address 0.
    next();
    pa(4'hF, 4'd12, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h0);
    pb(4'hF, 4'd0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0);
    next(); pa(4'h0, 4'd12, 32'h0, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
    next();
    repeat (3) next();
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_sweep_rst_busy_lat1", 32'(busy0), 32'd1);
    chk("mid_sweep_rst_busy_lat2", 32'(busy1), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sweep("rst_restart", 1'b0);
    next(); pa(4'h0, 4'd12, 32'h0, 32'h0, 32'h0); pb(4'h0, 4'd0, 32'h0, 32'h0, 32'h0);
    next(); pa(4'h0, 4'd15, 32'h0, 32'h0, 32'h0); pb(4'h0, 4'd9, 32'h0, 32'h0, 32'h0);
    next();

    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) chk({pname(i), "_pending_at_end"}, 32'(qsize(i)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dp_be_clr.md
Name: ram_dp_be_clr

Overview:
- Single-clock true dual-port RAM with per-byte write enables, configurable read latency, selectable read-during-write mode and a hardware clear engine.
- Next-generation building block for the CAM and L2 switch tables (MAC table, port map, aging RAM). Flush-on-reset and flush-on-demand are handled in hardware instead of by software sweeps.
- Two independent read/write ports share one storage array. Each read result carries a valid strobe.

Parameters:
DATA_WIDTH, 32, word width; must be an integer multiple of BYTE_WIDTH
ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH
BYTE_WIDTH, 8, write-enable granularity; BE_WIDTH = DATA_WIDTH/BYTE_WIDTH
READ_LATENCY, 1, 1 or 2 cycles from accepted read to dout/valid; 2 adds an output register
WRITE_MODE, 0, 0 = write-first (same-port read returns new data), 1 = read-first (returns old data)
CLEAR_ON_RESET, 1, 1 = start a clear sweep automatically when rst deasserts

Ports:
clk  in  1  clock for both ports
rst  in  1  asynchronous, active-high reset
clear_start  in  1  one-cycle request to zero the whole array
busy  out  1  high while a clear sweep is in progress
a_en  in  1  port A access request
a_we  in  BE_WIDTH  port A byte write enables; 0 = read only
a_addr  in  ADDR_WIDTH  port A address
a_din  in  DATA_WIDTH  port A write data
a_dout  out  DATA_WIDTH  port A read data
a_valid  out  1  port A read data valid, one-cycle pulse
b_en, b_we, b_addr, b_din, b_dout, b_valid: same as port A, for port B

Behaviour:
- Reset (async, rst=1):
  - a_dout, b_dout, all pipeline registers = 0; a_valid, b_valid = 0; clear counter = 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, otherwise IDLE; busy follows the FSM state immediately.
  - Array contents are not reset directly; only the clear sweep zeroes them.
- FSM has two states:
  - IDLE: busy=0, port accesses are accepted. clear_start=1 moves to CLEAR on the next edge; no access is accepted in the cycle clear_start is sampled.
  - CLEAR: busy=1. Writes 0 to address counter, then increments: one word per cycle, 2**ADDR_WIDTH cycles. After writing the last address, returns to IDLE and busy drops on that edge.
  - clear_start during CLEAR is ignored; the sweep does not restart.
  - rst during CLEAR restarts from address 0 (if CLEAR_ON_RESET=1) or aborts to IDLE.
- While busy=1, all a_en/b_en are ignored: no writes, no valid pulses, dout holds its value.
- Access accepted when en=1 and FSM is in IDLE with clear_start=0.
  - Write: for each byte i with we[i]=1, that byte of mem[addr] takes din's byte. Other bytes are unchanged.
  - Every accepted access, write or read, produces a read result: valid=1 exactly READ_LATENCY cycles later, with dout updated on that same edge.
  - dout holds its value between results. Back-to-back accesses give one result per cycle.
- Same-port read-during-write:
  - WRITE_MODE=0: dout shows the merged word (new bytes where we=1, old bytes elsewhere).
  - WRITE_MODE=1: dout shows the old word.
- Cross-port, same address, same cycle:
  - Both ports writing: each byte enabled by both ports takes a_din (port A wins). A byte enabled by only one port takes that port's data.
  - One port reads while the other writes: the reader returns the old word.
- Address is ADDR_WIDTH bits, so there is no out-of-range case. The clear counter wraps only by terminating the sweep.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> busy=1 for exactly 16 cycles. Afterwards, a read of each address returns 0 with valid one cycle later (READ_LATENCY=1).
- Port A writes 0xDEADBEEF to addr 3 with we=1111, then writes we=0010 din=0x00005500 -> a port B read of addr 3 returns 0xDEAD55EF. With READ_LATENCY=2, b_valid rises 2 cycles after b_en.
- WRITE_MODE=0 vs 1: mem[5]=0x11111111; port A writes 0x22222222 to addr 5 -> a_dout = 0x22222222 in mode 0, 0x11111111 in mode 1.
- Same cycle: A writes 0xAAAAAAAA we=0011, B writes 0xBBBBBBBB we=0110, both to addr 7 (previously 0) -> mem[7]=0x00BBAAAA. A port B read of addr 7 concurrent with an A write returns the old value.
- clear_start after filling the array -> busy for 2**ADDR_WIDTH cycles. a_en pulses during the sweep yield no a_valid. A second clear_start mid-sweep does not extend busy. All words read 0 afterwards.
- rst asserted mid-sweep (counter=9), then released -> sweep restarts at 0 and busy lasts the full 2**ADDR_WIDTH cycles. dout=0 and valid=0 while rst=1.
